// File: rtl/uart_program_loader.sv
// UART program loader: receives a word-count header plus big-endian
// instruction words over 8N1 serial and writes them to instruction memory.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_HDR_HI,
        L_HDR_LO,
        L_WORD,
        L_WRITE,
        L_FINISH
    } ld_state_t;

    // receiver state
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic        byte_valid;
    logic        stop_err;

    // loader state
    ld_state_t   ld_state;
    ld_state_t   ld_next;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [15:0] index;
    logic [15:0] index_next;
    logic [1:0]  bcnt;
    logic [1:0]  bcnt_next;
    logic [31:0] data;
    logic [31:0] data_next;
    logic        busy_next;
    logic [31:0] waddr_next;
    logic [31:0] wdata_next;
    logic        ferr_set;
    logic [15:0] n_words;
    logic [15:0] index_inc;

    // two-flop synchronizer plus previous-sample register for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // receiver state register and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state <= R_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            rx_state <= rx_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
        end
    end

    // receiver next-state: mid-bit sampling, glitch reject, stop check
    always_comb begin
        rx_next    = rx_state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_next  = R_START;
                    cnt_next = '0;
                end
            end
            R_START: begin
                if (cnt == HALF_END) begin
                    cnt_next = '0;
                    bit_next = '0;
                    rx_next  = rx_sync ? R_IDLE : R_DATA;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            R_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        rx_next = R_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            R_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_next = '0;
                    rx_next  = R_IDLE;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    // loader state register, write port registers and sticky error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_state  <= L_HDR_HI;
            count     <= '0;
            index     <= '0;
            bcnt      <= '0;
            data      <= '0;
            busy      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            ld_state  <= ld_next;
            count     <= count_next;
            index     <= index_next;
            bcnt      <= bcnt_next;
            data      <= data_next;
            busy      <= busy_next;
            wr_addr   <= waddr_next;
            wr_data   <= wdata_next;
            frame_err <= frame_err | ferr_set;
        end
    end

    assign n_words   = {count[15:8], shift};
    assign index_inc = index + 16'd1;

    // loader next-state: header parse, word assembly, write and finish
    always_comb begin
        ld_next    = ld_state;
        count_next = count;
        index_next = index;
        bcnt_next  = bcnt;
        data_next  = data;
        busy_next  = busy;
        waddr_next = wr_addr;
        wdata_next = wr_data;
        ferr_set   = stop_err;
        wr_en      = 1'b0;
        done       = 1'b0;
        if (stop_err) begin
            busy_next = 1'b0;
            ld_next   = L_HDR_HI;
        end else begin
            unique case (ld_state)
                L_HDR_HI: begin
                    if (byte_valid) begin
                        count_next = {shift, count[7:0]};
                        busy_next  = 1'b1;
                        ld_next    = L_HDR_LO;
                    end
                end
                L_HDR_LO: begin
                    if (byte_valid) begin
                        count_next = n_words;
                        if (n_words == 16'd0) begin
                            busy_next = 1'b0;
                            ld_next   = L_FINISH;
                        end else if ({1'b0, n_words} > MAX_N) begin
                            ferr_set  = 1'b1;
                            busy_next = 1'b0;
                            ld_next   = L_HDR_HI;
                        end else begin
                            index_next = '0;
                            bcnt_next  = '0;
                            ld_next    = L_WORD;
                        end
                    end
                end
                L_WORD: begin
                    if (byte_valid) begin
                        data_next = {data[23:0], shift};
                        bcnt_next = bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            waddr_next = {14'b0, index, 2'b00};
                            wdata_next = {data[23:0], shift};
                            ld_next    = L_WRITE;
                        end
                    end
                end
                L_WRITE: begin
                    wr_en      = 1'b1;
                    index_next = index_inc;
                    if (index_inc == count) begin
                        busy_next = 1'b0;
                        ld_next   = L_FINISH;
                    end else begin
                        ld_next = L_WORD;
                    end
                end
                L_FINISH: begin
                    done    = 1'b1;
                    ld_next = L_HDR_HI;
                end
                default: ld_next = L_HDR_HI;
            endcase
        end
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Receives a program image over a UART serial line and writes it, one 32-bit instruction word at a time, into the processor's instruction memory. It is the writer side of the instruction-fetch path: the fetch stage reads words at byte addresses 0, 4, 8, …, and this block fills exactly those addresses. It sits between the board's RX pin and the instruction memory's write port, and holds `busy` high so the core can be kept stalled while a load is in progress.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `MAX_WORDS`, default 256: instruction-memory capacity in words.
- `clock`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: UART serial input, idle high, 8N1, LSB first; asynchronous to `clock`.
- `wr_en`  out  1: one-cycle write strobe to instruction memory.
- `wr_addr`  out  32: byte address of the word being written (always a multiple of 4).
- `wr_data`  out  32: instruction word being written.
- `busy`  out  1: load in progress.
- `done`  out  1: one-cycle pulse, load completed.
- `frame_err`  out  1: sticky flag, bad stop bit or oversize count seen.

## Operation
- RX front end: `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- Byte receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on a synchronized 1→0 edge, go to START and clear the bit-timer.
  - START: at `CLKS_PER_BIT/2` cycles, sample. If low, go to DATA; if high (glitch), return to IDLE with no byte.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into a shift register.
  - STOP: sample after `CLKS_PER_BIT` cycles. If high, emit `byte_valid` for one cycle. If low, set `frame_err` and emit no byte. Return to IDLE either way.
- Packet format: 2-byte word count N (big-endian), then N words of 4 bytes each, big-endian (MSB byte first).
- Loader FSM: HDR_HI → HDR_LO → WORD → WRITE → (WORD | FINISH) → HDR_HI.
  - HDR_HI: first byte latched into count[15:8]; `busy` is set.
  - HDR_LO: count[7:0] latched.
    - N = 0: go to FINISH.
    - N > `MAX_WORDS`: set `frame_err`, clear `busy`, return to HDR_HI.
    - Otherwise: word index and byte counter cleared, go to WORD.
  - WORD: bytes are shifted into the assembly register, `data = {data[23:0], byte}`. After the 4th byte, go to WRITE.
  - WRITE: assert `wr_en` for one cycle with `wr_addr = index*4` and `wr_data` = assembled word, then increment index.
    - If index+1 = N, go to FINISH.
    - Otherwise go to WORD.
  - FINISH: `done` high for one cycle, `busy` cleared, go to HDR_HI. A new load may follow immediately.
- Frame error during a load: the bad byte is discarded, `busy` is cleared, the loader returns to HDR_HI, and words already written remain in memory. `frame_err` stays set until `reset`.
- Address arithmetic: index is 16 bits wide. `wr_addr = {14'b0, index, 2'b00}`.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `frame_err`=0; both FSMs in their first state; counters 0.
- Latency:
  - `byte_valid` fires 2 cycles (synchronizer) + mid-stop-bit sample after the line's stop-bit centre.
  - `wr_en` is asserted the cycle after the 4th byte's `byte_valid`.
  - `done` is asserted the cycle after the last `wr_en`.
  - For N = 0, `done` is asserted the cycle after the count-low `byte_valid`.
- `wr_addr` and `wr_data` are valid only while `wr_en`=1 and hold their values otherwise.
- Back-to-back frames with no idle time between stop and start are accepted. The falling-edge detector is re-armed on entry to IDLE.
- Reset asserted mid-frame or mid-load: everything is cleared immediately; no `wr_en` is emitted.

## Test plan
- `CLKS_PER_BIT`=16; send 00 02, 20 08 00 05, 8C 09 00 04 → `wr_en` at addr 0x0 with data 0x20080005, then at addr 0x4 with data 0x8C090004; `done` pulses once; `busy` falls with `done`; `frame_err`=0.
- Send 00 00 → no `wr_en`; `done` pulses the cycle after the 2nd byte.
- Drive `rx` low for 5 cycles, then high → no byte received; state returns to IDLE; no output change.
- Send 00 01, then a byte with stop bit = 0 → `frame_err`=1, `busy`=0, no `wr_en`; a following valid packet 00 01, 00 00 00 2A writes 0x0000002A at addr 0.
- With `MAX_WORDS`=4, send 00 05 → `frame_err`=1, `busy`=0, no writes.
- Assert `reset` after 2 of 4 word bytes → all outputs 0; a fresh packet 00 01, 12 34 56 78 writes 0x12345678 at addr 0.
